fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of program_counter. It consumes `pc`, issues one instruction-memory read at a time over a valid/ready handshake, and queues returned words with their PC in a small FIFO for decode.
- It produces `pc_next` for program_counter: hold, +4 or redirect target. It therefore closes the PC loop and replaces the free-running `pc + 4` connection.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default widths and the sequential instruction step.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_t;

    localparam int DEFAULT_DEPTH  = 2;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;
    localparam int INST_STEP      = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer holding {pc, instruction} pairs for decode.
// Flush has priority over a same-cycle push or pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc_mem[tail]   <= push_pc;
                data_mem[tail] <= push_data;
                tail           <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_valid = (count != '0);
    assign head_pc    = pc_mem[head];
    assign head_data  = data_mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one imem read at a time, buffers returned
// words with their PC, and closes the PC loop through pc_next.
// Optional macro FETCH_MISALIGN_CHECK_EN enables the sticky fetch_misaligned flag.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_misaligned
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic              drop;
    logic              drop_next;
    logic [ADDR_W-1:0] req_pc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;
    logic              handshake;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target_aligned;

    assign imem_req_valid = (state == S_REQ) && !reset;
    assign imem_req_addr  = pc;
    assign handshake      = imem_req_valid && imem_req_ready;
    assign pop            = inst_valid && inst_ready;
    assign push           = (state == S_WAIT) && imem_resp_valid && !drop && !redirect_valid;
    assign count_after    = count + CNT_W'(push) - CNT_W'(pop);
    assign target_aligned = {redirect_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        pc_next = pc;
        if (reset) begin
            pc_next = pc;
        end else if (redirect_valid) begin
            pc_next = target_aligned;
        end else if (handshake) begin
            pc_next = pc + ADDR_W'(INST_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            drop   <= 1'b0;
            req_pc <= '0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
            if (handshake) begin
                req_pc <= pc;
            end
        end
    end

    // A request already accepted must still have its response swallowed,
    // so a redirect only reaches S_IDLE once nothing is outstanding.
    always_comb begin
        state_next = state;
        drop_next  = drop;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && (count < CNT_W'(DEPTH))) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (handshake) begin
                    state_next = S_WAIT;
                    if (redirect_valid) begin
                        drop_next = 1'b1;
                    end
                end else if (redirect_valid) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    drop_next = 1'b0;
                    if (redirect_valid) begin
                        state_next = S_IDLE;
                    end else if (count_after < CNT_W'(DEPTH)) begin
                        state_next = S_REQ;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                drop_next  = 1'b0;
            end
        endcase
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (req_pc),
        .push_data  (imem_resp_data),
        .pop        (pop),
        .head_valid (inst_valid),
        .head_pc    (inst_pc),
        .head_data  (inst_data),
        .count      (count)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_misaligned <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            fetch_misaligned <= 1'b1;
        end
    end
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];
    assign fetch_misaligned   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a program_counter register
// and a simple imem model whose response delay can be stretched.
module tb_fetch_unit;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [DATA_W-1:0] imem_resp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              fetch_misaligned;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .pc_next          (pc_next),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_data        (inst_data),
        .inst_pc          (inst_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    // program_counter stand-in
    always @(posedge clk) begin
        if (reset) pc <= '0;
        else       pc <= pc_next;
    end

    // Memory returns DEAD0000 + address, resp_delay cycles after a 1-cycle baseline.
    logic              mem_pending = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    int                mem_wait = 0;
    int                resp_delay = 0;

    always @(posedge clk) begin
        if (reset) begin
            mem_pending <= 1'b0;
        end else begin
            if (imem_resp_valid) mem_pending <= 1'b0;
            else if (mem_pending && mem_wait > 0) mem_wait <= mem_wait - 1;
            if (imem_req_valid && imem_req_ready) begin
                mem_pending <= 1'b1;
                mem_addr    <= imem_req_addr;
                mem_wait    <= resp_delay;
            end
        end
    end

    assign imem_resp_valid = mem_pending && (mem_wait == 0);
    assign imem_resp_data  = 32'hDEAD_0000 + mem_addr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] tgt, input logic ir, input logic rr);
        redirect_valid  = rv;
        redirect_target = tgt;
        inst_ready      = ir;
        imem_req_ready  = rr;
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (!imem_req_valid && n < 40) begin
            step();
            n++;
        end
        checkOutput(tag, imem_req_valid, 1);
    endtask

    task automatic waitReqAddr(input logic [31:0] addr, input string tag);
        int n = 0;
        while (!(imem_req_valid && imem_req_addr == addr) && n < 40) begin
            step();
            n++;
        end
        checkOutput(tag, imem_req_addr, addr);
        checkOutput({tag, "_valid"}, imem_req_valid, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b1);
        repeat (3) step();
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_inst_data", inst_data, 0);
        checkOutput("rst_inst_pc", inst_pc, 0);
        checkOutput("rst_misaligned", fetch_misaligned, 0);
        checkOutput("rst_pc_next", pc_next, 0);

        // Streaming: 1-cycle memory, decode always ready
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("idle_after_reset", imem_req_valid, 0);
        step();
        checkOutput("req0_valid", imem_req_valid, 1);
        checkOutput("req0_addr", imem_req_addr, 32'h0);
        checkOutput("req0_pc_next", pc_next, 32'h4);
        step();
        checkOutput("wait0_req_valid", imem_req_valid, 0);
        checkOutput("wait0_pc_next", pc_next, 32'h4);
        step();
        checkOutput("inst0_valid", inst_valid, 1);
        checkOutput("inst0_pc", inst_pc, 32'h0);
        checkOutput("inst0_data", inst_data, 32'hDEAD_0000);
        checkOutput("req4_addr", imem_req_addr, 32'h4);
        step();
        step();
        checkOutput("inst4_pc", inst_pc, 32'h4);
        checkOutput("inst4_data", inst_data, 32'hDEAD_0004);
        checkOutput("req8_addr", imem_req_addr, 32'h8);
        step();
        step();
        checkOutput("inst8_pc", inst_pc, 32'h8);
        checkOutput("inst8_data", inst_data, 32'hDEAD_0008);
        checkOutput("reqC_addr", imem_req_addr, 32'hC);

        // Decode stall fills the buffer
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        step();
        checkOutput("full_req_valid", imem_req_valid, 0);
        checkOutput("full_pc_next", pc_next, 32'h10);
        checkOutput("full_head_pc", inst_pc, 32'h8);
        step();
        checkOutput("full_req_valid2", imem_req_valid, 0);
        checkOutput("full_pc_next2", pc_next, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        checkOutput("pop_head_pc", inst_pc, 32'hC);
        checkOutput("pop_head_data", inst_data, 32'hDEAD_000C);

        // imem not ready for three cycles
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_req_valid", imem_req_valid, 1);
            checkOutput("stall_req_addr", imem_req_addr, 32'h10);
            checkOutput("stall_pc_next", pc_next, 32'h10);
        end
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("ready_pc_next", pc_next, 32'h14);
        checkOutput("ready_req_addr", imem_req_addr, 32'h10);

        // Redirect while waiting on the 0x8 response
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        step();
        checkOutput("rerst_inst_valid", inst_valid, 0);
        reset = 1'b0;
        waitReqAddr(32'h8, "wait_req8");
        checkOutput("pre_redirect_head", inst_pc, 32'h4);
        resp_delay = 3;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        #1;
        checkOutput("redir_pc_next", pc_next, 32'h100);
        checkOutput("pre_flush_valid", inst_valid, 1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("flush_inst_valid", inst_valid, 0);
        checkOutput("drop_req_valid", imem_req_valid, 0);
        waitReq("req_after_redirect");
        checkOutput("redir_req_addr", imem_req_addr, 32'h100);
        checkOutput("no_stale_entry", inst_valid, 0);
        resp_delay = 0;
        step();
        checkOutput("wait100_inst_valid", inst_valid, 0);
        step();
        checkOutput("inst100_valid", inst_valid, 1);
        checkOutput("inst100_pc", inst_pc, 32'h100);
        checkOutput("inst100_data", inst_data, 32'hDEAD_0100);
        checkOutput("req104_addr", imem_req_addr, 32'h104);

        // Redirect coincident with response and pop
        step();
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        #1;
        checkOutput("coin_pc_next", pc_next, 32'h200);
        checkOutput("coin_head_valid", inst_valid, 1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("coin_flush_valid", inst_valid, 0);
        checkOutput("coin_idle", imem_req_valid, 0);
        step();
        checkOutput("coin_no_stale", inst_valid, 0);
        checkOutput("req200_addr", imem_req_addr, 32'h200);

        // Redirect near the top of the address space, then wrap
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        #1;
        checkOutput("top_pc_next", pc_next, 32'hFFFF_FFFC);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("top_idle", imem_req_valid, 0);
        checkOutput("aligned_no_flag", fetch_misaligned, 0);
        step();
        checkOutput("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_next", pc_next, 32'h0);
        step();
        step();
        checkOutput("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
        checkOutput("top_inst_data", inst_data, 32'hDEAC_FFFC);
        checkOutput("wrapped_req_addr", imem_req_addr, 32'h0);

        // Misaligned redirect
        applyStimulus(1'b1, 32'h102, 1'b1, 1'b1);
        #1;
        checkOutput("mis_pc_next", pc_next, 32'h100);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("mis_flag", fetch_misaligned, EXP_MIS);
        repeat (3) step();
        checkOutput("mis_flag_sticky", fetch_misaligned, EXP_MIS);
        reset = 1'b1;
        step();
        checkOutput("mis_flag_reset", fetch_misaligned, 0);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
